// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the PC/ID/EX/MEM/MEM2/WB pipeline.
// Ports: clk/rst, stall and redirect sources in; per-stage wr/flush, redirect and div_done out.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icache_busy,
  input  logic            dcache_busy,
  input  logic            load_use,
  input  logic            div_start,
  input  logic            br_redirect,
  input  logic [PC_W-1:0] br_target,
  input  logic            exc_valid,
  input  logic [PC_W-1:0] exc_target,
  output logic            pc_wr,
  output logic            id_wr,
  output logic            ex_wr,
  output logic            mem_wr,
  output logic            mem2_wr,
  output logic            wb_wr,
  output logic            id_flush,
  output logic            ex_flush,
  output logic            mem_flush,
  output logic            mem2_flush,
  output logic            wb_flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            div_done
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    EXC_WAIT,
    BR_WAIT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   div_cnt;
  logic [PC_W-1:0] tgt_q;
  logic [PC_W-1:0] last_pc;
  logic [PC_W-1:0] sel_pc;

  logic       div_stall;
  logic       stall;
  logic [2:0] k;
  logic       exc_take;
  logic       br_take;
  logic [5:0] wr_s;
  logic [5:1] fl_s;
  logic [5:0] wr;
  logic [5:1] fl;
  logic       rv;

  assign div_stall = div_start | (div_cnt != '0);

  // Exceptions only act once MEM2 is done; a held MEM2 re-asserts.
  assign exc_take = exc_valid & ~dcache_busy;

  // Deepest stalled stage wins.
  always_comb begin
    stall = 1'b1;
    k     = 3'd0;
    if (dcache_busy)      k = 3'd4;
    else if (div_stall)   k = 3'd2;
    else if (load_use)    k = 3'd1;
    else if (icache_busy) k = 3'd0;
    else                  stall = 1'b0;
  end

  // A branch only redirects when EX is advancing.
  assign br_take = (state == RUN) & br_redirect & ~exc_take
                 & (~stall | (k < 3'd2));

  always_comb begin
    wr_s = '1;
    fl_s = '0;
    if (stall) begin
      for (int i = 0; i < 6; i++)
        if (3'(i) <= k) wr_s[i] = 1'b0;
      fl_s[k + 3'd1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (exc_take) begin
      state_nx = icache_busy ? EXC_WAIT : RUN;
    end else begin
      unique case (state)
        RUN:      if (br_take && icache_busy) state_nx = BR_WAIT;
        EXC_WAIT: if (!icache_busy) state_nx = RUN;
        BR_WAIT:  if (!icache_busy) state_nx = RUN;
        default:  state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    wr     = wr_s;
    fl     = fl_s;
    rv     = 1'b0;
    sel_pc = tgt_q;
    if (rst) begin
      wr = '0;
      fl = '1;
    end else if (exc_take) begin
      // Excepting instr's WB write is already squashed upstream.
      wr      = '1;
      wr[0]   = ~icache_busy;
      fl      = '0;
      fl[4:1] = '1;
      rv      = ~icache_busy;
      sel_pc  = exc_target;
    end else begin
      unique case (state)
        RUN: begin
          if (br_take) begin
            fl[1]  = 1'b1;
            wr[0]  = ~icache_busy;
            rv     = ~icache_busy;
            sel_pc = br_target;
          end
        end
        EXC_WAIT: begin
          wr    = '1;
          wr[0] = ~icache_busy;
          fl    = '0;
          fl[1] = 1'b1;
          rv    = ~icache_busy;
        end
        BR_WAIT: begin
          fl[1] = 1'b1;
          wr[0] = ~icache_busy;
          rv    = ~icache_busy;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      tgt_q <= '0;
    else if (exc_take && icache_busy)
      tgt_q <= exc_target;
    else if (br_take && icache_busy)
      tgt_q <= br_target;
  end

  always_ff @(posedge clk) begin
    if (rst)     last_pc <= '0;
    else if (rv) last_pc <= sel_pc;
  end

  always_ff @(posedge clk) begin
    if (rst || exc_take)
      div_cnt <= '0;
    else if (div_start)
      div_cnt <= CW'(DIV_CYCLES - 1);
    else if (div_cnt != '0)
      div_cnt <= div_cnt - 1'b1;
  end

  assign div_done = ~rst & ((div_cnt == CW'(1))
                  | (div_start & (DIV_CYCLES == 1)));

  assign pc_wr          = wr[0];
  assign id_wr          = wr[1];
  assign ex_wr          = wr[2];
  assign mem_wr         = wr[3];
  assign mem2_wr        = wr[4];
  assign wb_wr          = wr[5];
  assign id_flush       = fl[1];
  assign ex_flush       = fl[2];
  assign mem_flush      = fl[3];
  assign mem2_flush     = fl[4];
  assign wb_flush       = fl[5];
  assign redirect_valid = rv;
  assign redirect_pc    = rv ? sel_pc : last_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl.
// Expected outputs queued per driven cycle, compared at negedge.
module tb_pipe_ctrl;

  localparam int DIVC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_busy, dcache_busy, load_use;
  logic        div_start, br_redirect, exc_valid;
  logic [31:0] br_target, exc_target;
  logic        pc_wr, id_wr, ex_wr, mem_wr, mem2_wr, wb_wr;
  logic        id_flush, ex_flush, mem_flush, mem2_flush;
  logic        wb_flush, redirect_valid, div_done;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [5:0]  wr;
    logic [4:0]  fl;
    logic        rv;
    logic        dd;
    logic        pc_chk;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_CYCLES(DIVC), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .icache_busy(icache_busy), .dcache_busy(dcache_busy),
    .load_use(load_use), .div_start(div_start),
    .br_redirect(br_redirect), .br_target(br_target),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .pc_wr(pc_wr), .id_wr(id_wr), .ex_wr(ex_wr),
    .mem_wr(mem_wr), .mem2_wr(mem2_wr), .wb_wr(wb_wr),
    .id_flush(id_flush), .ex_flush(ex_flush),
    .mem_flush(mem_flush), .mem2_flush(mem2_flush),
    .wb_flush(wb_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .div_done(div_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ":wr"}, 32'({wb_wr, mem2_wr, mem_wr,
          ex_wr, id_wr, pc_wr}), 32'(e.wr));
      chk({e.tag, ":fl"}, 32'({wb_flush, mem2_flush, mem_flush,
          ex_flush, id_flush}), 32'(e.fl));
      chk({e.tag, ":rv"}, 32'(redirect_valid), 32'(e.rv));
      chk({e.tag, ":dd"}, 32'(div_done), 32'(e.dd));
      if (e.pc_chk) chk({e.tag, ":pc"}, redirect_pc, e.pc);
    end
  end

  task automatic step(input string tag, input logic [5:0] wr,
                      input logic [4:0] fl, input logic rv,
                      input logic pc_chk, input logic [31:0] pc,
                      input logic dd);
    exp_t e;
    e.tag = tag; e.wr = wr; e.fl = fl; e.rv = rv;
    e.dd = dd; e.pc_chk = pc_chk; e.pc = pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic norm(input string tag);
    step(tag, 6'h3F, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic clr();
    rst = 1'b0; icache_busy = 1'b0; dcache_busy = 1'b0;
    load_use = 1'b0; div_start = 1'b0; br_redirect = 1'b0;
    exc_valid = 1'b0; br_target = '0; exc_target = '0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("rst0", 6'h00, 5'h1F, 1'b0, 1'b0, 32'h0, 1'b0);
    step("rst1", 6'h00, 5'h1F, 1'b0, 1'b1, 32'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) norm($sformatf("idle%0d", i));

    load_use = 1'b1;
    step("lu", 6'b111100, 5'b00010, 1'b0, 1'b0, 32'h0, 1'b0);
    dcache_busy = 1'b1;
    step("lu_dc", 6'b100000, 5'b10000, 1'b0, 1'b0, 32'h0, 1'b0);
    clr();
    icache_busy = 1'b1;
    step("ic", 6'b111110, 5'b00001, 1'b0, 1'b0, 32'h0, 1'b0);
    clr();

    div_start = 1'b1;
    step("div0", 6'b111000, 5'b00100, 1'b0, 1'b0, 32'h0, 1'b0);
    div_start = 1'b0;
    for (int i = 1; i < DIVC; i++)
      step($sformatf("div%0d", i), 6'b111000, 5'b00100, 1'b0,
           1'b0, 32'h0, (i == DIVC - 1));
    norm("div_end");

    exc_valid = 1'b1; exc_target = 32'hBFC0_0380; icache_busy = 1'b1;
    step("exc0", 6'b111110, 5'b01111, 1'b0, 1'b0, 32'h0, 1'b0);
    exc_valid = 1'b0; exc_target = 32'h0;
    step("excw1", 6'b111110, 5'b00001, 1'b0, 1'b0, 32'h0, 1'b0);
    step("excw2", 6'b111110, 5'b00001, 1'b0, 1'b0, 32'h0, 1'b0);
    icache_busy = 1'b0;
    step("excr", 6'h3F, 5'b00001, 1'b1, 1'b1, 32'hBFC0_0380, 1'b0);
    step("exc_hold", 6'h3F, 5'h00, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0);

    br_redirect = 1'b1; br_target = 32'h8000_1000; dcache_busy = 1'b1;
    step("br_dc", 6'b100000, 5'b10000, 1'b0, 1'b0, 32'h0, 1'b0);
    dcache_busy = 1'b0;
    step("br", 6'h3F, 5'b00001, 1'b1, 1'b1, 32'h8000_1000, 1'b0);
    clr();
    norm("br_post");

    exc_valid = 1'b1; exc_target = 32'h8000_0180;
    step("exc_imm", 6'h3F, 5'b01111, 1'b1, 1'b1, 32'h8000_0180, 1'b0);
    dcache_busy = 1'b1;
    step("exc_dc", 6'b100000, 5'b10000, 1'b0, 1'b0, 32'h0, 1'b0);
    clr();

    br_redirect = 1'b1; br_target = 32'h8000_2000; icache_busy = 1'b1;
    step("brw0", 6'b111110, 5'b00001, 1'b0, 1'b0, 32'h0, 1'b0);
    br_redirect = 1'b0; load_use = 1'b1;
    step("brw_lu", 6'b111100, 5'b00011, 1'b0, 1'b0, 32'h0, 1'b0);
    load_use = 1'b0; icache_busy = 1'b0; dcache_busy = 1'b1;
    step("brw_dc", 6'b100001, 5'b10001, 1'b1, 1'b1, 32'h8000_2000, 1'b0);
    clr();
    norm("brw_post");

    br_redirect = 1'b1; br_target = 32'h8000_3000; icache_busy = 1'b1;
    step("brx0", 6'b111110, 5'b00001, 1'b0, 1'b0, 32'h0, 1'b0);
    br_redirect = 1'b0; icache_busy = 1'b0;
    exc_valid = 1'b1; exc_target = 32'hBFC0_0200;
    step("brx_exc", 6'h3F, 5'b01111, 1'b1, 1'b1, 32'hBFC0_0200, 1'b0);
    clr();
    norm("brx_post");

    exc_valid = 1'b1; exc_target = 32'h1111_0000; icache_busy = 1'b1;
    step("exA", 6'b111110, 5'b01111, 1'b0, 1'b0, 32'h0, 1'b0);
    exc_target = 32'h2222_0000;
    step("exB", 6'b111110, 5'b01111, 1'b0, 1'b0, 32'h0, 1'b0);
    exc_valid = 1'b0; icache_busy = 1'b0;
    step("exBr", 6'h3F, 5'b00001, 1'b1, 1'b1, 32'h2222_0000, 1'b0);
    clr();

    div_start = 1'b1;
    step("dx0", 6'b111000, 5'b00100, 1'b0, 1'b0, 32'h0, 1'b0);
    div_start = 1'b0; exc_valid = 1'b1; exc_target = 32'h8000_0180;
    step("dx_exc", 6'h3F, 5'b01111, 1'b1, 1'b1, 32'h8000_0180, 1'b0);
    clr();
    norm("dx_post");

    div_start = 1'b1;
    step("dr0", 6'b111000, 5'b00100, 1'b0, 1'b0, 32'h0, 1'b0);
    div_start = 1'b0;
    for (int i = 1; i < 4; i++)
      step($sformatf("dr%0d", i), 6'b111000, 5'b00100, 1'b0,
           1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    step("dr_rst", 6'h00, 5'h1F, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    norm("dr_post");

    clr();
    repeat (2) @(posedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
